lcd_field_display: RTL and testbench

LCD_FIELD_DISPLAY -- requirements
Module: lcd_field_display

---
 rtl/lcd_field_display_if.sv | 23 ++
 rtl/lcd_field_display.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_field_display.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_field_display_if.sv
// Avalon-MM write port between the field display controller and a character LCD.
// The controller drives the master side; the LCD (or a bench) drives the slave side.
interface lcd_field_display_if;
    logic       address;
    logic       chipselect;
    logic       write;
    logic       read;
    logic       byteenable;
    logic [7:0] writedata;
    logic       waitrequest;
    logic [7:0] readdata;
    logic [1:0] response;

    modport master (
        output address, chipselect, write, read, byteenable, writedata,
        input  waitrequest, readdata, response
    );

    modport slave (
        input  address, chipselect, write, read, byteenable, writedata,
        output waitrequest, readdata, response
    );
endinterface

// File: rtl/lcd_field_display.sv
// Character-LCD status display for the robot: shows command, target bearing and
// (optionally) target-detected flag. Initialises the LCD after reset, then redraws
// a frame from a registered snapshot whenever the inputs change or a refresh is due.
module lcd_field_display #(
    parameter int unsigned FOV            = 25,
    parameter int unsigned DIR_DIGITS     = 2,
    parameter int unsigned CMD_MAX        = 5,
    parameter int unsigned TWO_LINE       = 1,
    parameter int unsigned REFRESH_CYCLES = 0,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             command,
    input  logic [$clog2(FOV):0]   direction,
    input  logic                   target_valid,
    input  logic                   force_refresh,
    lcd_field_display_if.master    bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             err_count
);

    // Sequence index: 0..1 are the init writes, 2.. are the frame writes.
    localparam int unsigned FrameLen    = 10 + DIR_DIGITS + ((TWO_LINE != 0) ? 6 : 0);
    localparam int unsigned SeqLen      = 2 + FrameLen;
    localparam int unsigned IdxW        = $clog2(SeqLen);
    localparam int unsigned LastIdx     = SeqLen - 1;
    localparam int          Line2Pos    = 10 + int'(DIR_DIGITS);
    localparam int unsigned RefreshLoad = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;

    typedef enum logic [2:0] {StInit, StIdle, StSnap, StWrite, StGap} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       seq_idx_q, seq_idx_d;
    logic [31:0]           wait_cnt_q, wait_cnt_d;
    logic [7:0]            err_q;
    logic                  pend_q;
    logic [2:0]            snap_cmd_q;
    logic [$clog2(FOV):0]  snap_dir_q;
    logic                  snap_tv_q;
    logic [31:0]           ref_cnt_q;

    logic                  strobe;
    logic                  err_inc;
    logic                  snap_load;
    logic                  pend_clr;
    logic                  go;
    logic                  ref_expired;
    logic                  inputs_changed;
    logic                  wr_addr;
    logic [7:0]            wr_data;
    logic [7:0]            cmd_char;
    logic                  dir_bad;
    int                    frame_pos;
    logic                  unused_readdata;

    assign unused_readdata = ^bus.readdata;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < int'(DIR_DIGITS); i++) begin
            if (i < n) r = r * 10;
        end
        return r;
    endfunction

    // Decimal digit at position pos (0 = units) by repeated subtraction, MSD first.
    function automatic logic [3:0] dir_digit(input int unsigned value, input int pos);
        int unsigned rem;
        int unsigned pw;
        logic [3:0]  d;
        logic [3:0]  sel;
        rem = value;
        sel = '0;
        for (int p = int'(DIR_DIGITS) - 1; p >= 0; p--) begin
            pw = pow10(p);
            d  = '0;
            for (int k = 0; k < 9; k++) begin
                if (rem >= pw) begin
                    rem = rem - pw;
                    d   = d + 4'd1;
                end
            end
            if (p == pos) sel = d;
        end
        return sel;
    endfunction

    assign frame_pos      = int'(32'(seq_idx_q)) - 2;
    assign cmd_char       = (32'(snap_cmd_q) <= CMD_MAX) ? (8'h30 + {5'b0, snap_cmd_q}) : "#";
    assign dir_bad        = 32'(snap_dir_q) > FOV;
    assign inputs_changed = {command, direction, target_valid} !=
                            {snap_cmd_q, snap_dir_q, snap_tv_q};
    assign ref_expired    = (REFRESH_CYCLES != 0) && (ref_cnt_q == 32'd0);
    assign go             = inputs_changed | pend_q | force_refresh | ref_expired;

    // Byte and register select for the write at the current sequence index.
    always_comb begin
        wr_addr = 1'b0;
        wr_data = 8'h00;
        if (seq_idx_q == '0) begin
            wr_data = 8'h01;
        end else if (seq_idx_q == IdxW'(1)) begin
            wr_data = 8'h0C;
        end else if (frame_pos == 0) begin
            wr_data = 8'h80;
        end else if (frame_pos < 10) begin
            wr_addr = 1'b1;
            case (frame_pos)
                1:       wr_data = "C";
                2:       wr_data = "m";
                3:       wr_data = "d";
                4:       wr_data = ":";
                5:       wr_data = cmd_char;
                6:       wr_data = " ";
                7:       wr_data = "D";
                8:       wr_data = "r";
                default: wr_data = ":";
            endcase
        end else if (frame_pos < Line2Pos) begin
            wr_addr = 1'b1;
            wr_data = dir_bad ? "#" :
                      (8'h30 + {4'b0, dir_digit(32'(snap_dir_q), Line2Pos - 1 - frame_pos)});
        end else if (frame_pos == Line2Pos) begin
            wr_data = 8'hC0;
        end else begin
            wr_addr = 1'b1;
            case (frame_pos - Line2Pos)
                1:       wr_data = "T";
                2:       wr_data = "g";
                3:       wr_data = "t";
                4:       wr_data = ":";
                default: wr_data = snap_tv_q ? "Y" : "N";
            endcase
        end
    end

    // Next-state logic: write handshake, gaps, timeout and frame sequencing.
    always_comb begin
        state_d    = state_q;
        seq_idx_d  = seq_idx_q;
        wait_cnt_d = wait_cnt_q;
        strobe     = 1'b0;
        err_inc    = 1'b0;
        snap_load  = 1'b0;
        pend_clr   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StInit: begin
                seq_idx_d  = '0;
                wait_cnt_d = '0;
                state_d    = StWrite;
            end
            StIdle: begin
                if (go) begin
                    pend_clr = 1'b1;
                    state_d  = StSnap;
                end
            end
            StSnap: begin
                snap_load = 1'b1;
                state_d   = StWrite;
            end
            StWrite: begin
                strobe = 1'b1;
                if (!bus.waitrequest) begin
                    wait_cnt_d = '0;
                    err_inc    = (bus.response != 2'b00);
                    if (seq_idx_q == IdxW'(LastIdx)) begin
                        frame_done = 1'b1;
                        seq_idx_d  = IdxW'(2);
                        state_d    = StIdle;
                    end else if (seq_idx_q == IdxW'(1)) begin
                        // SNAP doubles as the idle cycle between init and frame.
                        seq_idx_d = IdxW'(2);
                        state_d   = StSnap;
                    end else begin
                        seq_idx_d = seq_idx_q + IdxW'(1);
                        state_d   = StGap;
                    end
                end else if (wait_cnt_q == TIMEOUT - 1) begin
                    err_inc    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StInit;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StGap: begin
                state_d = StWrite;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // FSM and sequence registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StInit;
            seq_idx_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_idx_q  <= seq_idx_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Snapshot, pending refresh, error counter and refresh timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= '0;
            pend_q     <= 1'b0;
            snap_cmd_q <= '0;
            snap_dir_q <= '0;
            snap_tv_q  <= 1'b0;
            ref_cnt_q  <= RefreshLoad;
        end else begin
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            pend_q <= pend_clr ? 1'b0 : (pend_q | force_refresh);
            if (snap_load) begin
                snap_cmd_q <= command;
                snap_dir_q <= direction;
                snap_tv_q  <= target_valid;
            end
            if (frame_done) begin
                ref_cnt_q <= RefreshLoad;
            end else if (ref_cnt_q != 32'd0) begin
                ref_cnt_q <= ref_cnt_q - 32'd1;
            end
        end
    end

    assign bus.chipselect = strobe;
    assign bus.write      = strobe;
    assign bus.address    = strobe & wr_addr;
    assign bus.writedata  = strobe ? wr_data : 8'h00;
    assign bus.read       = 1'b0;
    assign bus.byteenable = 1'b1;
    assign busy           = (state_q != StIdle);
    assign err_count      = err_q;

endmodule

// File: tb/tb_lcd_field_display.sv
// Directed bench for lcd_field_display: init/frame content, invalid-value rendering,
// waitrequest stalls, timeout recovery, error counting and refresh/reset behaviour.
module tb_lcd_field_display;
    localparam int unsigned Timeout = 1024;

    logic       clk;
    logic       reset;
    logic [2:0] command;
    logic [5:0] direction;
    logic       target_valid;
    logic       force_refresh;
    logic       busy;
    logic       frame_done;
    logic [7:0] err_count;

    lcd_field_display_if bus ();

    lcd_field_display #(
        .FOV            (25),
        .DIR_DIGITS     (2),
        .CMD_MAX        (5),
        .TWO_LINE       (1),
        .REFRESH_CYCLES (0),
        .TIMEOUT        (Timeout)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .command       (command),
        .direction     (direction),
        .target_valid  (target_valid),
        .force_refresh (force_refresh),
        .bus           (bus),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_count     (err_count)
    );

    int         checks = 0;
    int         failures = 0;
    int         fd_cnt = 0;
    int         c_hold = 0;
    int         cyc = 0;
    logic [8:0] acc_q[$];
    int         acc_t[$];
    logic [8:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Log accepted writes and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.chipselect && bus.write && !bus.waitrequest) begin
                acc_q.push_back({bus.address, bus.writedata});
                acc_t.push_back(cyc);
            end
            if (frame_done) fd_cnt = fd_cnt + 1;
            if (bus.chipselect && bus.writedata == 8'h43) c_hold = c_hold + 1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
    endtask

    task automatic build_frame(input int c, input int d, input bit tv, input bit with_init);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(9'h001);
            exp_q.push_back(9'h00C);
        end
        exp_q.push_back(9'h080);
        push_str("Cmd:");
        exp_q.push_back(c <= 5 ? {1'b1, 8'(48 + c)} : {1'b1, 8'h23});
        push_str(" Dr:");
        if (d > 25) begin
            push_str("##");
        end else begin
            exp_q.push_back({1'b1, 8'(48 + d / 10)});
            exp_q.push_back({1'b1, 8'(48 + d % 10)});
        end
        exp_q.push_back(9'h0C0);
        push_str("Tgt:");
        push_str(tv ? "Y" : "N");
    endtask

    task automatic compare_log(input string tag, input int mark);
        check({tag, "_len"}, acc_q.size() - mark, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (mark + i < acc_q.size())
                check($sformatf("%s[%0d]", tag, i), acc_q[mark + i], exp_q[i]);
        end
    endtask

    task automatic wait_fd(input int target, input string tag);
        int k;
        k = 0;
        while (fd_cnt < target && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_done"}, fd_cnt >= target, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k;
        k = 0;
        while (acc_q.size() < n && k < 500) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({tag, "_acc"}, acc_q.size() >= n, 1);
    endtask

    task automatic pulse_refresh();
        force_refresh = 1'b1;
        @(posedge clk);
        #2;
        force_refresh = 1'b0;
    endtask

    int mark;
    int fd0;
    int hold0;
    int n;
    int k;
    int bad;

    initial begin
        reset = 1'b1;
        command = 3'd3;
        direction = 6'd17;
        target_valid = 1'b1;
        force_refresh = 1'b0;
        bus.waitrequest = 1'b0;
        bus.readdata = 8'h00;
        bus.response = 2'd0;
        repeat (3) @(posedge clk);
        #2;

        // Reset state
        check("rst_cs", bus.chipselect, 0);
        check("rst_wr", bus.write, 0);
        check("rst_addr", bus.address, 0);
        check("rst_wd", bus.writedata, 0);
        check("rst_busy", busy, 1);
        check("rst_fd", frame_done, 0);
        check("rst_err", err_count, 0);

        // Init plus first frame, no stalls
        mark = acc_q.size();
        fd0 = fd_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_cs", bus.chipselect, 1);
        check("first_wd", bus.writedata, 8'h01);
        #1;
        wait_fd(fd0 + 1, "f1");
        build_frame(3, 17, 1'b1, 1'b1);
        compare_log("f1", mark);
        bad = 0;
        for (int i = mark + 1; i < acc_t.size(); i++)
            if (acc_t[i] - acc_t[i - 1] != 2) bad++;
        check("f1_gap", bad, 0);
        check("f1_fd_once", fd_cnt - fd0, 1);
        check("f1_busy", busy, 0);

        // Out-of-range command, then out-of-range direction
        mark = acc_q.size();
        fd0 = fd_cnt;
        command = 3'd7;
        wait_fd(fd0 + 1, "cmd7");
        build_frame(7, 17, 1'b1, 1'b0);
        compare_log("cmd7", mark);
        mark = acc_q.size();
        fd0 = fd_cnt;
        direction = 6'd30;
        wait_fd(fd0 + 1, "dir30");
        build_frame(7, 30, 1'b1, 1'b0);
        compare_log("dir30", mark);
        fd0 = fd_cnt;
        repeat (60) @(posedge clk);
        #2;
        check("no_refire", fd_cnt - fd0, 0);
        check("idle_busy", busy, 0);

        // Stall the 4th write ('C') for 5 cycles
        command = 3'd3;
        direction = 6'd17;
        reset = 1'b1;
        @(posedge clk);
        #2;
        mark = acc_q.size();
        fd0 = fd_cnt;
        hold0 = c_hold;
        reset = 1'b0;
        wait_acc(mark + 3, "stall_pre");
        bus.waitrequest = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        bus.waitrequest = 1'b0;
        wait_fd(fd0 + 1, "stall");
        check("stall_hold", c_hold - hold0, 6);
        n = 0;
        for (int i = mark; i < acc_q.size(); i++) if (acc_q[i] == 9'h143) n++;
        check("stall_once", n, 1);
        build_frame(3, 17, 1'b1, 1'b1);
        compare_log("stall", mark);

        // waitrequest stuck high until timeout
        reset = 1'b1;
        @(posedge clk);
        #2;
        bus.waitrequest = 1'b1;
        mark = acc_q.size();
        fd0 = fd_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        while (bus.chipselect && n < 3000) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("to_stall", n, Timeout);
        check("to_err", err_count, 1);
        check("to_wd", bus.writedata, 0);
        @(posedge clk);
        #1;
        check("to_re_cs", bus.chipselect, 1);
        check("to_re_wd", bus.writedata, 8'h01);
        check("to_no_acc", acc_q.size() - mark, 0);
        #1;
        bus.waitrequest = 1'b0;
        wait_fd(fd0 + 1, "to_frame");
        check("to_err_keep", err_count, 1);

        // Error responses on three writes, then saturation
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("err_rst", err_count, 0);
        bus.response = 2'd2;
        mark = acc_q.size();
        fd0 = fd_cnt;
        reset = 1'b0;
        wait_acc(mark + 3, "err3");
        bus.response = 2'd0;
        wait_fd(fd0 + 1, "err3");
        check("err3", err_count, 3);
        bus.response = 2'd2;
        n = acc_q.size();
        k = 0;
        while (acc_q.size() - n < 300 && k < 20000) begin
            if (!busy) pulse_refresh();
            else begin
                @(posedge clk);
                #2;
            end
            k++;
        end
        bus.response = 2'd0;
        k = 0;
        while (busy && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("sat_idle", busy, 0);
        check("err_sat", err_count, 255);

        // Two refresh pulses during a forced frame give one extra frame
        fd0 = fd_cnt;
        pulse_refresh();
        repeat (8) @(posedge clk);
        #2;
        pulse_refresh();
        repeat (4) @(posedge clk);
        #2;
        pulse_refresh();
        repeat (300) @(posedge clk);
        #2;
        check("refresh_once", fd_cnt - fd0, 2);

        // Reset in the middle of a write
        mark = acc_q.size();
        pulse_refresh();
        wait_acc(mark + 4, "mid");
        @(posedge clk);
        #2;
        check("mid_cs_before", bus.chipselect, 1);
        reset = 1'b1;
        #1;
        check("mid_cs", bus.chipselect, 0);
        check("mid_wr", bus.write, 0);
        check("mid_addr", bus.address, 0);
        check("mid_wd", bus.writedata, 0);
        check("mid_busy", busy, 1);
        check("mid_err", err_count, 0);
        @(posedge clk);
        #2;
        mark = acc_q.size();
        fd0 = fd_cnt;
        reset = 1'b0;
        wait_fd(fd0 + 1, "mid_re");
        build_frame(3, 17, 1'b1, 1'b1);
        compare_log("mid_re", mark);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
